// File: rtl/pulse_stretcher.sv
// Widens a single-cycle rising edge on trigger into a programmable-length high
// level, followed by an optional forced-low holdoff gap; drops and flags excess edges.
module pulse_stretcher #(
    parameter int CNT_WIDTH   = 8,
    parameter int HOLDOFF_LEN = 2,
    parameter bit RETRIGGER   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 stretched,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ACTIVE  = 3'b010,
        HOLDOFF = 3'b100
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_M1 =
        (HOLDOFF_LEN == 0) ? '0 : CNT_WIDTH'(HOLDOFF_LEN - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 trig_q;
    logic                 trig_edge;
    logic [CNT_WIDTH-1:0] load_val;

    assign trig_edge = trigger & ~trig_q;
    // len==0 behaves as a one-cycle stretch, so the reload value is clamped at 0.
    assign load_val  = (len == '0) ? '0 : len - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            trig_q  <= 1'b1;
            overrun <= 1'b0;
        end else begin
            trig_q  <= trigger;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state <= ACTIVE;
                        cnt   <= load_val;
                    end
                end
                ACTIVE: begin
                    if (trig_edge && RETRIGGER) begin
                        cnt <= load_val;
                    end else begin
                        if (trig_edge) overrun <= 1'b1;
                        if (cnt == '0) begin
                            if (HOLDOFF_LEN == 0) begin
                                state <= IDLE;
                            end else begin
                                state <= HOLDOFF;
                                cnt   <= HOLD_M1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (trig_edge) overrun <= 1'b1;
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stretched = (state == ACTIVE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: three configurations share one stimulus stream and are
// compared against a timeline model of stretch/holdoff end cycles.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b1;
    logic [7:0] len = 8'd5;
    logic [2:0] st, bz, ov;

    always #5 clk = ~clk;

    pulse_stretcher #(.CNT_WIDTH(8), .HOLDOFF_LEN(2), .RETRIGGER(1'b1)) u0 (
        .clk(clk), .reset(reset), .trigger(trigger), .len(len),
        .stretched(st[0]), .busy(bz[0]), .overrun(ov[0]));
    pulse_stretcher #(.CNT_WIDTH(8), .HOLDOFF_LEN(2), .RETRIGGER(1'b0)) u1 (
        .clk(clk), .reset(reset), .trigger(trigger), .len(len),
        .stretched(st[1]), .busy(bz[1]), .overrun(ov[1]));
    pulse_stretcher #(.CNT_WIDTH(8), .HOLDOFF_LEN(0), .RETRIGGER(1'b1)) u2 (
        .clk(clk), .reset(reset), .trigger(trigger), .len(len),
        .stretched(st[2]), .busy(bz[2]), .overrun(ov[2]));

    typedef struct {
        logic [2:0] st;
        logic [2:0] bz;
        logic [2:0] ov;
        longint     cyc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     failures = 0;

    // Model: last cycle of the stretch and last busy cycle per instance.
    int     HO[3] = '{2, 2, 0};
    bit     RT[3] = '{1'b1, 1'b0, 1'b1};
    longint act_end[3];
    longint busy_end[3];
    bit     prev_trig;
    longint t = 0;

    task automatic step(input bit r, input bit tr, input int l);
        exp_t   e;
        longint leff;
        @(negedge clk);
        reset   = r;
        trigger = tr;
        len     = l[7:0];
        e.st = '0; e.bz = '0; e.ov = '0; e.cyc = t + 1;
        leff = (l == 0) ? 1 : l;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                act_end[k]  = -1;
                busy_end[k] = -1;
            end else if (tr && !prev_trig) begin
                if (t <= act_end[k]) begin
                    if (RT[k]) begin
                        act_end[k]  = t + leff;
                        busy_end[k] = act_end[k] + HO[k];
                    end else begin
                        e.ov[k] = 1'b1;
                    end
                end else if (t <= busy_end[k]) begin
                    e.ov[k] = 1'b1;
                end else begin
                    act_end[k]  = t + leff;
                    busy_end[k] = act_end[k] + HO[k];
                end
            end
            e.st[k] = (t + 1 <= act_end[k]);
            e.bz[k] = (t + 1 <= busy_end[k]);
        end
        prev_trig = r ? 1'b1 : tr;
        q.push_back(e);
        t++;
    endtask

    task automatic idle(input int n, input int l);
        for (int i = 0; i < n; i++) step(0, 0, l);
    endtask

    // Monitor: every cycle the DUTs present outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (st[k] !== e.st[k]) begin
                        failures++;
                        $display("FAIL stretched u%0d cyc=%0d got=%b exp=%b", k, e.cyc, st[k], e.st[k]);
                    end
                    checks++;
                    if (bz[k] !== e.bz[k]) begin
                        failures++;
                        $display("FAIL busy u%0d cyc=%0d got=%b exp=%b", k, e.cyc, bz[k], e.bz[k]);
                    end
                    checks++;
                    if (ov[k] !== e.ov[k]) begin
                        failures++;
                        $display("FAIL overrun u%0d cyc=%0d got=%b exp=%b", k, e.cyc, ov[k], e.ov[k]);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            act_end[k]  = -1;
            busy_end[k] = -1;
        end
        prev_trig = 1'b1;

        // Reset with trigger already high, then hold it: must not fire.
        repeat (3) step(1, 1, 5);
        repeat (5) step(0, 1, 5);
        idle(3, 5);
        // Basic stretch, len=5.
        step(0, 1, 5); idle(10, 5);
        // Held level with len=0: one-cycle stretch, no refire.
        repeat (20) step(0, 1, 0);
        idle(5, 0);
        // Retrigger on the last active cycle, len=4.
        step(0, 1, 4); idle(3, 4); step(0, 1, 4); idle(12, 4);
        // Holdoff boundaries, len=3: edge on last holdoff cycle, then first idle cycle.
        step(0, 1, 3); idle(4, 3); step(0, 1, 3); idle(10, 3);
        step(0, 1, 3); idle(5, 3); step(0, 1, 3); idle(10, 3);
        // Reset mid-stretch, then a full len=8 stretch.
        step(0, 1, 8); idle(2, 8); step(1, 0, 8); idle(3, 8);
        step(0, 1, 8); idle(14, 8);
        // Reset mid-holdoff.
        step(0, 1, 2); idle(3, 2); step(1, 0, 2); idle(3, 2);
        // Widest length, no wrap past zero.
        step(0, 1, 255); idle(262, 255);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, tr;
            int l;
            r  = ($urandom_range(0, 199) == 0);
            tr = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            step(r, tr, l);
        end
        idle(4, 1);

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
